sin_lut_arbiter: RTL and testbench
==================================

// Module: sin_lut_arbiter
// PURPOSE
//   Time-shares one quarter-wave sine LUT (2-cycle pipelined, 10-bit phase in, Q14 out)
//   among N_REQ requesters, e.g. per-oscillator force units in the energy landscape.
//   Round-robin grant, one lookup issued per cycle, requester ID carried alongside the
//   LUT pipeline so every result returns tagged. Also counts contention cycles.
// PARAMETERS
//   N_REQ    4   number of requesters (>=2)
//   WIDTH    18  signed Q14 sine width
//   PHASE_W  10  phase width (0..1023 = 0..2pi)
//   LUT_LAT  2   LUT latency: lut_phase to lut_sin, in clock edges
//   CNT_W    16  contention counter width
// PORTS
//   clk           in   1                clock, all logic on posedge
//   rst_n         in   1                async active-low reset
//   req           in   N_REQ            request; held high with its phase until granted
//   req_phase     in   N_REQ*PHASE_W    phase of requester i at [i*PHASE_W +: PHASE_W]
//   gnt           out  N_REQ            one-hot, combinational; request accepted this cycle
//   lut_phase     out  PHASE_W          registered phase driven to the LUT
//   lut_sin       in   WIDTH            signed LUT result
//   rsp_valid     out  1                registered; result valid this cycle
//   rsp_id        out  $clog2(N_REQ)    requester that owns rsp_sin
//   rsp_sin       out  WIDTH            signed Q14 result
//   busy          out  1                any lookup in flight (issue or tag stages valid)
//   conflict_cnt  out  CNT_W            saturating count of cycles with >=2 req high
// BEHAVIOUR
//   Interface: one clock, clk; reset rst_n, asynchronous, active-low.
//   - Reset: ptr=0; issue/tag valids=0; lut_phase=0; rsp_valid=0; rsp_id=0; rsp_sin=0;
//     conflict_cnt=0. gnt=0 while rst_n low. In-flight lookups are dropped and never
//     return after reset release.
//   - Arbitration: scan req starting at ptr, wrapping at N_REQ; grant the first set bit.
//     At most one gnt bit high. On grant to i, ptr <= (i+1) mod N_REQ. No req: gnt=0,
//     ptr holds.
//   - Issue, grant cycle T: at edge T, lut_phase <= req_phase[i], tag stage 0 <= {1,i}.
//     No grant: lut_phase holds its value and tag stage 0 valid <= 0.
//   - Tag pipeline: LUT_LAT further stages shift {valid,id} in lockstep with the LUT.
//     The tail is valid in cycle T+1+LUT_LAT, when lut_sin holds the result.
//   - Response: at edge T+1+LUT_LAT, rsp_valid <= tail valid. If tail valid, rsp_id and
//     rsp_sin load; otherwise they hold. rsp_valid is high in cycle T+LUT_LAT+2
//     (=T+4 at default).
//   - Throughput: 1 lookup per cycle. Responses leave in grant order and are never
//     reordered or dropped. No backpressure: consumers must accept rsp_valid.
//   - Requester may re-request in the cycle after its grant. With all requesters busy,
//     each is served once every N_REQ cycles.
//   - busy = OR of tag-stage valids (stage 0..tail).
//   - conflict_cnt: +1 on any edge where popcount(req)>=2. Holds at 2^CNT_W-1.
//   - Widths: no arithmetic on sin data. rsp_sin is passed bit-exact from lut_sin.
// STRUCTURE
//   - Shared header sin_lut_defs.vh: PHASE_W, Q14 WIDTH/FRAC, LUT_LAT default,
//     ID width macro.
//   - Sub-module rr_arbiter (req, ptr -> one-hot gnt, next ptr), reusable elsewhere.
//   - Top: issue register, tag shift register [0:LUT_LAT], response register,
//     saturating counter.
// TESTING
//   (bench instantiates the real sine LUT on lut_phase/lut_sin)
//   1. Single req[0], phase=256, in cycle T -> gnt=0001 in T; rsp_valid in T+4,
//      rsp_id=0, rsp_sin=+16384.
//   2. req[2] with phase 0, 512, 768 on consecutive grants -> back-to-back rsp_sin
//      0, 0, -16384, all rsp_id=2, no gaps.
//   3. All 4 req held high for 8 cycles -> gnt 0,1,2,3,0,1,2,3; rsp_id same order on
//      8 consecutive cycles; conflict_cnt=8.
//   4. ptr=2, req=1010 -> gnt=1000 first, then 0010; rsp_id 3 then 1.
//   5. rst_n low for 1 cycle with 2 lookups in flight -> rsp_valid=0, busy=0 at once;
//      no rsp after release; next grant goes to req[0] first (ptr=0).
//   6. CNT_W=4, 20 cycles with req=0011 -> conflict_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/sin_lut_arbiter_pkg.sv
// Shared constants for the time-shared sine LUT arbiter: phase/Q14 widths,
// LUT latency default and the requester-ID width helper.
package sin_lut_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int WIDTH_DEF   = 18;
  localparam int PHASE_W_DEF = 10;
  localparam int LUT_LAT_DEF = 2;
  localparam int CNT_W_DEF   = 16;

  // Width of a requester ID; never below one bit so ports stay legal.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sin_lut_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans req from ptr with wrap, grants the first set bit
// and returns the pointer just past the winner.
module sin_lut_arbiter_rr_arbiter
  import sin_lut_arbiter_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id,
  output logic [ID_W-1:0]  o_next_ptr,
  output logic             o_any
);

  int unsigned     w_sum;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned; no latch.
    o_gnt    = '0;
    o_gnt_id = '0;
    o_any    = 1'b0;
    w_sum    = 0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_idx = ID_W'(w_sum);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = w_idx;
      end
    end
    o_next_ptr = (int'(o_gnt_id) == N_REQ - 1) ? '0 : o_gnt_id + ID_W'(1);
  end

endmodule

// File: rtl/sin_lut_arbiter.sv
// Shares one pipelined quarter-wave sine LUT among N_REQ requesters; results
// return tagged with the owner's ID, and contention cycles are counted.
module sin_lut_arbiter
  import sin_lut_arbiter_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int PHASE_W = PHASE_W_DEF,
  parameter  int LUT_LAT = LUT_LAT_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int ID_W    = id_w(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*PHASE_W-1:0] req_phase,
  output logic [N_REQ-1:0]         gnt,
  output logic [PHASE_W-1:0]       lut_phase,
  input  logic signed [WIDTH-1:0]  lut_sin,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic signed [WIDTH-1:0]  rsp_sin,
  output logic                     busy,
  output logic [CNT_W-1:0]         conflict_cnt
);

  logic [ID_W-1:0]          r_ptr;
  logic [ID_W-1:0]          w_gnt_id;
  logic [ID_W-1:0]          w_next_ptr;
  logic [N_REQ-1:0]         w_gnt_raw;
  logic                     w_any;
  logic                     w_conflict;
  logic [PHASE_W-1:0]       w_phase;
  logic [PHASE_W-1:0]       r_lut_phase;
  logic [LUT_LAT:0]         r_tag_vld;
  logic [ID_W-1:0]          r_tag_id [LUT_LAT+1];
  logic                     r_rsp_valid;
  logic [ID_W-1:0]          r_rsp_id;
  logic signed [WIDTH-1:0]  r_rsp_sin;
  logic [CNT_W-1:0]         r_cnt;

  sin_lut_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req      (req),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt_raw),
    .o_gnt_id   (w_gnt_id),
    .o_next_ptr (w_next_ptr),
    .o_any      (w_any)
  );

  assign gnt        = rst_n ? w_gnt_raw : '0;
  assign w_conflict = $countones(req) >= 2;

  // One-hot mux of the winning requester's phase.
  always_comb begin
    w_phase = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt_raw[k]) w_phase = req_phase[k*PHASE_W +: PHASE_W];
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_lut_phase <= '0;
      r_tag_vld   <= '0;
    end else begin
      if (w_any) begin
        r_ptr       <= w_next_ptr;
        r_lut_phase <= w_phase;
      end
      r_tag_vld <= {r_tag_vld[LUT_LAT-1:0], w_any};
    end
  end

  // NOTE: the ID array is not reset; its valid bits qualify it, so only those need reset.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt_id;
    for (int k = 1; k <= LUT_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
  end

  // Tail of the tag pipe lines up with lut_sin; capture both together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sin   <= '0;
    end else begin
      r_rsp_valid <= r_tag_vld[LUT_LAT];
      if (r_tag_vld[LUT_LAT]) begin
        r_rsp_id  <= r_tag_id[LUT_LAT];
        r_rsp_sin <= lut_sin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_conflict && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign lut_phase    = r_lut_phase;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_sin      = r_rsp_sin;
  assign busy         = |r_tag_vld;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sin_lut_arbiter.sv
// Bench for sin_lut_arbiter: sine LUT stand-in, a queue-based response model
// checked every cycle, and directed scenarios with literal expectations.
module tb_sin_lut_arbiter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req;
  logic [39:0]        req_phase;
  logic [3:0]         gnt, gnt4;
  logic [9:0]         lut_phase, lut_phase4;
  logic signed [17:0] lut_sin, lut_s1;
  logic               rsp_valid, rsp_valid4;
  logic [1:0]         rsp_id, rsp_id4;
  logic signed [17:0] rsp_sin, rsp_sin4;
  logic               busy, busy4;
  logic [15:0]        conflict_cnt;
  logic [3:0]         cnt4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sin_lut_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_phase(req_phase), .gnt(gnt),
    .lut_phase(lut_phase), .lut_sin(lut_sin), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sin(rsp_sin), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  sin_lut_arbiter #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_phase(req_phase), .gnt(gnt4),
    .lut_phase(lut_phase4), .lut_sin(lut_sin), .rsp_valid(rsp_valid4),
    .rsp_id(rsp_id4), .rsp_sin(rsp_sin4), .busy(busy4), .conflict_cnt(cnt4)
  );

  function automatic int sine_q14(input int p);
    real r;
    r = $sin(6.283185307179586 * p / 1024.0) * 16384.0;
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(0.5 - r);
  endfunction

  // Two-stage LUT: lut_phase -> lut_sin in two clock edges.
  always @(posedge clk) begin
    lut_s1  <= 18'(sine_q14(int'(lut_phase)));
    lut_sin <= lut_s1;
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model, checked every cycle ----------------
  typedef struct { int due; int id; int sin; } exp_t;
  exp_t q[$];
  int m_ptr = 0, m_cnt16 = 0, m_cnt4 = 0, m_last_id = 0, m_last_sin = 0, m_lut_phase = 0;
  int m_gid, m_nreq;
  bit m_ev, m_busy;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt", gnt, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", conflict_cnt, 0);
      check("rst_cnt4", cnt4, 0);
      check("rst_lut_phase", lut_phase, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_sin", rsp_sin, 0);
      q.delete();
      m_ptr = 0; m_cnt16 = 0; m_cnt4 = 0;
      m_last_id = 0; m_last_sin = 0; m_lut_phase = 0;
    end else begin
      m_nreq = $countones(req);
      m_gid  = -1;
      for (int k = 0; k < 4; k++)
        if (m_gid < 0 && req[(m_ptr + k) % 4]) m_gid = (m_ptr + k) % 4;
      check("m_gnt", gnt, (m_gid < 0) ? 0 : (1 << m_gid));
      m_ev = (q.size() > 0) && (q[0].due == cyc);
      if (m_ev) begin
        m_last_id  = q[0].id;
        m_last_sin = q[0].sin;
        void'(q.pop_front());
      end
      check("m_rsp_valid", rsp_valid, m_ev);
      check("m_rsp_id", rsp_id, m_last_id);
      check("m_rsp_sin", rsp_sin, m_last_sin);
      m_busy = 1'b0;
      foreach (q[k]) if (cyc >= q[k].due - 3 && cyc <= q[k].due - 1) m_busy = 1'b1;
      check("m_busy", busy, m_busy);
      check("m_lut_phase", lut_phase, m_lut_phase);
      check("m_cnt", conflict_cnt, m_cnt16);
      check("m_cnt4", cnt4, m_cnt4);
      if (m_gid >= 0) begin
        m_lut_phase = int'(req_phase[m_gid*10 +: 10]);
        q.push_back('{cyc + 4, m_gid, sine_q14(m_lut_phase)});
        m_ptr = (m_gid + 1) % 4;
      end
      if (m_nreq >= 2) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
  end

  // ---------------- logs for the directed scenarios ----------------
  typedef struct { int c; int id; int sin; } log_t;
  log_t rsp_log[$];
  log_t gnt_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) rsp_log.push_back('{cyc, int'(rsp_id), int'(rsp_sin)});
      for (int k = 0; k < 4; k++) if (gnt[k]) gnt_log.push_back('{cyc, k, 0});
    end
  end

  function automatic log_t rsp_at(input int k);
    if (k < rsp_log.size()) return rsp_log[k];
    return '{-1, -1, -99999};
  endfunction

  function automatic log_t gnt_at(input int k);
    if (k < gnt_log.size()) return gnt_log[k];
    return '{-1, -1, -99999};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rsp_log.delete();
    gnt_log.delete();
  endtask

  task automatic reset_pulse();
    req   = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    rst_n     = 1'b0;
    req       = '0;
    req_phase = '0;
    tick(); tick();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_cnt", conflict_cnt, 0);
    check("reset_gnt", gnt, 0);
    rst_n = 1'b1;
    tick();

    // 1: single request, phase 256 -> +16384 four cycles after grant
    clear_logs();
    req_phase[0*10 +: 10] = 10'd256;
    req = 4'b0001;
    tick();
    req = '0;
    repeat (6) tick();
    check("t1_ngnt", gnt_log.size(), 1);
    check("t1_gnt_id", gnt_at(0).id, 0);
    t0 = gnt_at(0).c;
    check("t1_nrsp", rsp_log.size(), 1);
    check("t1_latency", rsp_at(0).c - t0, 4);
    check("t1_rsp_id", rsp_at(0).id, 0);
    check("t1_rsp_sin", rsp_at(0).sin, 16384);

    // 2: back-to-back lookups from requester 2
    clear_logs();
    req = 4'b0100;
    req_phase[2*10 +: 10] = 10'd0;   tick();
    req_phase[2*10 +: 10] = 10'd512; tick();
    req_phase[2*10 +: 10] = 10'd768; tick();
    req = '0;
    repeat (6) tick();
    check("t2_nrsp", rsp_log.size(), 3);
    check("t2_sin0", rsp_at(0).sin, 0);
    check("t2_sin1", rsp_at(1).sin, 0);
    check("t2_sin2", rsp_at(2).sin, -16384);
    for (int k = 0; k < 3; k++) check("t2_id", rsp_at(k).id, 2);
    check("t2_gap01", rsp_at(1).c - rsp_at(0).c, 1);
    check("t2_gap12", rsp_at(2).c - rsp_at(1).c, 1);

    // 3: all four requesting for eight cycles
    reset_pulse();
    clear_logs();
    for (int k = 0; k < 4; k++) req_phase[k*10 +: 10] = 10'(k * 64 + 32);
    req = 4'b1111;
    repeat (8) tick();
    req = '0;
    check("t3_cnt", conflict_cnt, 8);
    repeat (8) tick();
    check("t3_ngnt", gnt_log.size(), 8);
    check("t3_nrsp", rsp_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("t3_gnt_order", gnt_at(k).id, k % 4);
      check("t3_rsp_order", rsp_at(k).id, k % 4);
    end
    check("t3_rsp_span", rsp_at(7).c - rsp_at(0).c, 7);

    // 4: ptr=2 with req=1010 -> requester 3 first, then 1
    req = 4'b0010;
    tick();
    req = '0;
    repeat (5) tick();
    clear_logs();
    req = 4'b1010;
    tick();
    req = 4'b0010;
    tick();
    req = '0;
    repeat (6) tick();
    check("t4_gnt0", gnt_at(0).id, 3);
    check("t4_gnt1", gnt_at(1).id, 1);
    check("t4_rsp0", rsp_at(0).id, 3);
    check("t4_rsp1", rsp_at(1).id, 1);

    // 5: reset with two lookups in flight
    clear_logs();
    req = 4'b0001; tick();
    req = 4'b0010; tick();
    req = '0;
    rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_gnt", gnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) tick();
    check("t5_no_rsp", rsp_log.size(), 0);
    clear_logs();
    req = 4'b1001; tick();
    req = 4'b1000; tick();
    req = '0;
    repeat (6) tick();
    check("t5_first_gnt", gnt_at(0).id, 0);
    check("t5_second_gnt", gnt_at(1).id, 3);

    // 6: saturation of a 4-bit counter
    reset_pulse();
    req = 4'b0011;
    repeat (20) tick();
    req = '0;
    check("t6_cnt4_sat", cnt4, 15);
    check("t6_cnt16", conflict_cnt, 20);
    repeat (6) tick();
    check("t6_cnt4_hold", cnt4, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
